// File: rtl/parcnn_pkg.sv
// Shared definitions for the parcnn datapath: word width, packer FSM states
// and the count-width helper used by the packer and the adder-tree front end.
package parcnn_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } packer_state_t;

  // Width of a counter that must represent 1..tree_size inclusive.
  function automatic int count_width(input int tree_size);
    return $clog2(tree_size) + 1;
  endfunction

endpackage

// File: rtl/vector_out_stage.sv
// Valid/ready holding register for one packed vector with its word count and
// packet-end flag; a load wins over a consume on the same edge.
module vector_out_stage
  import parcnn_pkg::*;
#(
  parameter int TREE_SIZE = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 i_load,
  input  logic [WORD_WIDTH*TREE_SIZE-1:0]      i_vector,
  input  logic [count_width(TREE_SIZE)-1:0]    i_count,
  input  logic                                 i_last,
  input  logic                                 i_out_ready,
  output logic [WORD_WIDTH*TREE_SIZE-1:0]      o_vector,
  output logic [count_width(TREE_SIZE)-1:0]    o_count,
  output logic                                 o_last,
  output logic                                 o_valid,
  output logic                                 o_slot_free
);

  logic [WORD_WIDTH*TREE_SIZE-1:0]   r_vector;
  logic [count_width(TREE_SIZE)-1:0] r_count;
  logic                              r_last;
  logic                              r_valid;

  assign o_slot_free = !r_valid || i_out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vector <= '0;
      r_count  <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_vector <= i_vector;
      r_count  <= i_count;
      r_last   <= i_last;
      r_valid  <= 1'b1;
    end else if (i_out_ready) begin
      // Payload is left in place; only the valid flag drops on a consume.
      r_valid  <= 1'b0;
    end
  end

  assign o_vector = r_vector;
  assign o_count  = r_count;
  assign o_last   = r_last;
  assign o_valid  = r_valid;

endmodule

// File: rtl/vector_packer_32bit.sv
// Packs a serial stream of 32-bit words into TREE_SIZE-slot vectors for the
// adder tree; short packets are zero-padded, long packets span several vectors.
module vector_packer_32bit
  import parcnn_pkg::*;
#(
  parameter int TREE_SIZE = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [WORD_WIDTH-1:0]                in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [WORD_WIDTH*TREE_SIZE-1:0]      out_vector,
  output logic [count_width(TREE_SIZE)-1:0]    out_count,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int CW = count_width(TREE_SIZE);
  localparam int FW = $clog2(TREE_SIZE);
  localparam int VW = WORD_WIDTH * TREE_SIZE;

  packer_state_t r_state;
  packer_state_t w_next_state;

  logic [FW-1:0] r_fill;
  logic [VW-1:0] r_buf;
  logic [CW-1:0] r_hold_count;
  logic          r_hold_last;
  logic          r_run;

  logic [VW-1:0] w_merged;
  logic [CW-1:0] w_fill_count;
  logic          w_accept;
  logic          w_complete;
  logic          w_slot_free;
  logic          w_load;
  logic [VW-1:0] w_load_vector;
  logic [CW-1:0] w_load_count;
  logic          w_load_last;

  // r_run keeps in_ready low while reset is held and for the release cycle.
  assign in_ready     = r_run && (r_state == ACCUM);
  assign w_accept     = in_valid && in_ready;
  assign w_complete   = w_accept && (in_last || (r_fill == FW'(TREE_SIZE - 1)));
  assign w_fill_count = CW'(r_fill) + CW'(1);

  always_comb begin
    w_merged = r_buf;
    for (int i = 0; i < TREE_SIZE; i++) begin
      if (r_fill == FW'(i)) w_merged[i*WORD_WIDTH +: WORD_WIDTH] = in_data;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_load_vector = w_merged;
    w_load_count  = w_fill_count;
    w_load_last   = in_last;
    unique case (r_state)
      ACCUM: begin
        if (w_complete) begin
          if (w_slot_free) w_load       = 1'b1;
          else             w_next_state = HOLD;
        end
      end
      HOLD: begin
        w_load_vector = r_buf;
        w_load_count  = r_hold_count;
        w_load_last   = r_hold_last;
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_next_state = ACCUM;
        end
      end
      default: w_next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ACCUM;
    else        r_state <= w_next_state;
  end

  // NOTE: the assembly buffer is reset explicitly because unused slots must
  // read as zero; a padded vector would otherwise carry stale words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf        <= '0;
      r_fill       <= '0;
      r_hold_count <= '0;
      r_hold_last  <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_load) begin
        r_buf  <= '0;
        r_fill <= '0;
      end else if (w_accept) begin
        r_buf <= w_merged;
        if (w_complete) begin
          // Output slot busy: park count/last alongside the buffer until HOLD drains.
          r_hold_count <= w_fill_count;
          r_hold_last  <= in_last;
        end else begin
          r_fill <= r_fill + 1'b1;
        end
      end
    end
  end

  vector_out_stage #(
    .TREE_SIZE (TREE_SIZE)
  ) u_out_stage (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_vector    (w_load_vector),
    .i_count     (w_load_count),
    .i_last      (w_load_last),
    .i_out_ready (out_ready),
    .o_vector    (out_vector),
    .o_count     (out_count),
    .o_last      (out_last),
    .o_valid     (out_valid),
    .o_slot_free (w_slot_free)
  );

endmodule

// File: tb/tb_vector_packer_32bit.sv
// Directed bench for vector_packer_32bit with TREE_SIZE=4: reset, full, short,
// single-word, backpressure and multi-vector packets.
module tb_vector_packer_32bit;

  localparam int TS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [127:0]  out_vector;
  logic [2:0]    out_count;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  vector_packer_32bit #(.TREE_SIZE(TS)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_vector (out_vector),
    .out_count  (out_count),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [127:0] vec, input int cnt,
                           input logic lst, input logic vld);
    check({tag, ".vector"}, out_vector, vec);
    check({tag, ".count"},  128'(out_count), 128'(cnt));
    check({tag, ".last"},   128'(out_last), 128'(lst));
    check({tag, ".valid"},  128'(out_valid), 128'(vld));
  endtask

  // Presents one word for exactly one edge; samples land 1 time unit later.
  task automatic send(input logic [31:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    idle(); idle();
    check_out("por", 128'd0, 0, 1'b0, 1'b0);
    check("por.in_ready", 128'(in_ready), 128'd0);
    reset = 1'b1;
    idle();
    check("rel.in_ready", 128'(in_ready), 128'd1);

    // Full vector
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0);
    check("full.pre_valid", 128'(out_valid), 128'd0);
    send(32'd4, 1'b0);
    check_out("full", {32'd4, 32'd3, 32'd2, 32'd1}, 4, 1'b0, 1'b1);
    idle();
    check("full.one_cycle", 128'(out_valid), 128'd0);

    // Reset mid-packet
    send(32'd77, 1'b0); send(32'd88, 1'b0);
    reset = 1'b0; #1;
    check_out("rst", 128'd0, 0, 1'b0, 1'b0);
    check("rst.in_ready", 128'(in_ready), 128'd0);
    idle();
    reset = 1'b1;
    idle();
    check("rst_rel.in_ready", 128'(in_ready), 128'd1);

    // Short packet: also proves the partial buffer was discarded
    send(32'hFFFF_FFFB, 1'b0);
    send(32'd7, 1'b1);
    check_out("short", {32'd0, 32'd0, 32'd7, 32'hFFFF_FFFB}, 2, 1'b1, 1'b1);

    // Single word then full packet
    send(32'd42, 1'b1);
    check_out("single", {32'd0, 32'd0, 32'd0, 32'd42}, 1, 1'b1, 1'b1);
    send(32'd9, 1'b0); send(32'd9, 1'b0); send(32'd9, 1'b0); send(32'd9, 1'b0);
    check_out("nines", {32'd9, 32'd9, 32'd9, 32'd9}, 4, 1'b0, 1'b1);
    idle();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    check_out("bp.first", {32'd4, 32'd3, 32'd2, 32'd1}, 4, 1'b0, 1'b1);
    for (int i = 5; i <= 7; i++) begin
      send(32'(i), 1'b0);
      check("bp.in_ready_accum", 128'(in_ready), 128'd1);
    end
    send(32'd8, 1'b0);
    check("bp.in_ready_hold", 128'(in_ready), 128'd0);
    in_data = 32'd99; in_valid = 1'b1;
    idle(); idle();
    in_valid = 1'b0;
    check_out("bp.stable", {32'd4, 32'd3, 32'd2, 32'd1}, 4, 1'b0, 1'b1);
    check("bp.still_held", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    check_out("bp.second", {32'd8, 32'd7, 32'd6, 32'd5}, 4, 1'b0, 1'b1);
    check("bp.in_ready_back", 128'(in_ready), 128'd1);
    idle();
    check_out("bp.second_stable", {32'd8, 32'd7, 32'd6, 32'd5}, 4, 1'b0, 1'b1);
    out_ready = 1'b1;
    idle();
    check("bp.drained", 128'(out_valid), 128'd0);

    // Long packet across two vectors
    send(32'd10, 1'b0); send(32'd11, 1'b0); send(32'd12, 1'b0); send(32'd13, 1'b0);
    check_out("long.v0", {32'd13, 32'd12, 32'd11, 32'd10}, 4, 1'b0, 1'b1);
    send(32'd14, 1'b0);
    check("long.gap", 128'(out_valid), 128'd0);
    send(32'd15, 1'b1);
    check_out("long.v1", {32'd0, 32'd0, 32'd15, 32'd14}, 2, 1'b1, 1'b1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
